// File: rtl/ooo_pkg.sv
// ooo_pkg: shared definitions for the in-order-dispatch, out-of-order-issue
// scheduler. It holds the opcode and sub-op constants, the FSM state type, the
// issue-queue entry layout and the instruction decode helpers.
//
// Instruction encoding, 8 bits:
//   [7:6] op      00 R-type, 01 I-type, 10 J, 11 HALT
//   [5:4] sub-op  I-type: 00 ADDI, 01 LD, 10 ST, 11 CMP (ignored for R-type)
//   [3:2] rs      source 0 (read by R-type only)
//   [1:0] rt      source 1 and destination
package ooo_pkg;

    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_I    = 2'b01;
    localparam logic [1:0] OP_J    = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [1:0] SUB_ADDI = 2'b00;
    localparam logic [1:0] SUB_LD   = 2'b01;
    localparam logic [1:0] SUB_ST   = 2'b10;
    localparam logic [1:0] SUB_CMP  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_JMP,
        CLS_HALT
    } iclass_t;

    // rdy[0] tracks rs, rdy[1] tracks rt; an unused source is stored as ready.
    typedef struct packed {
        logic       valid;
        logic [7:0] instr;
        logic [1:0] rdy;
    } entry_t;

    typedef struct packed {
        logic [1:0] use_src;
        logic [1:0] src0;
        logic [1:0] src1;
        logic       has_dest;
        logic [1:0] dest;
        iclass_t    cls;
    } dec_t;

    function automatic iclass_t iclass(input logic [7:0] instr);
        iclass_t c;
        c = CLS_ALU;
        case (instr[7:6])
            OP_I:    if (instr[5:4] == SUB_LD || instr[5:4] == SUB_ST) c = CLS_MEM;
            OP_J:    c = CLS_JMP;
            OP_HALT: c = CLS_HALT;
            default: c = CLS_ALU;
        endcase
        return c;
    endfunction

    // One-hot set of registers the instruction reads.
    function automatic logic [3:0] read_mask(input logic [7:0] instr);
        logic [3:0] m;
        m = 4'b0000;
        case (instr[7:6])
            OP_R:    m = (4'b0001 << instr[3:2]) | (4'b0001 << instr[1:0]);
            OP_I:    m = 4'b0001 << instr[1:0];
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic dec_t decode(input logic [7:0] instr);
        dec_t d;
        d          = '0;
        d.src0     = instr[3:2];
        d.src1     = instr[1:0];
        d.dest     = instr[1:0];
        d.cls      = iclass(instr);
        case (instr[7:6])
            OP_R: begin
                d.use_src  = 2'b11;
                d.has_dest = 1'b1;
            end
            OP_I: begin
                d.use_src  = 2'b10;
                d.has_dest = (instr[5:4] != SUB_ST);
            end
            default: begin
                d.use_src  = 2'b00;
                d.has_dest = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_select.sv
// issue_select: fixed-priority arbiter picking the oldest requesting entry.
// Ports:
//   req   - one request bit per queue slot, slot 0 is the oldest
//   grant - one-hot grant, lowest requesting index wins; all zero if no request
module issue_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered issue queue with a register busy scoreboard.
// Instructions enter in order, wait for their sources, and the oldest eligible
// one issues. Memory ops stay in order, J/HALT issue alone, and HALT stops the
// machine until reset.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   disp_valid/instr/ready  dispatch handshake from the front end
//   wb_valid, wb_reg        writeback broadcast clearing busy / waking sources
//   issue_valid/instr/ready issue handshake to execute
//   count                   occupied queue entries
//   halted                  HALT has issued (sticky)
//
// state     | meaning
// ST_RUN    | normal dispatch and issue
// ST_DRAIN  | HALT queued; no dispatch, older entries and HALT drain out
// ST_HALTED | HALT issued; nothing issues until reset
module issue_scheduler
    import ooo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_valid,
    input  logic [7:0]                 disp_instr,
    output logic                       disp_ready,
    input  logic                       wb_valid,
    input  logic [1:0]                 wb_reg,
    output logic                       issue_valid,
    output logic [7:0]                 issue_instr,
    input  logic                       issue_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);

    localparam int             CW   = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    entry_t           q     [DEPTH];
    entry_t           q_nxt [DEPTH];
    entry_t           new_e;
    logic [3:0]       busy, busy_nxt;
    logic [CW-1:0]    count_r, count_nxt;
    state_t           state, state_nxt;
    logic             live;
    logic [DEPTH-1:0] req, grant;
    logic             older_mem;
    dec_t             dd;
    logic [3:0]       dest_mask, war_mask;
    logic             do_disp, do_issue;
    int               gidx, wr_idx;

    issue_select #(.DEPTH(DEPTH)) u_select (
        .req   (req),
        .grant (grant)
    );

    // Eligibility: all sources ready, no older memory op for LD/ST, and J/HALT
    // only when they are the sole entry.
    always_comb begin
        req       = '0;
        older_mem = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && (&q[i].rdy) && state != ST_HALTED) begin
                case (iclass(q[i].instr))
                    CLS_MEM:  req[i] = !older_mem;
                    CLS_JMP,
                    CLS_HALT: req[i] = (i == 0) && (count_r == ONE);
                    default:  req[i] = 1'b1;
                endcase
            end
            if (q[i].valid && iclass(q[i].instr) == CLS_MEM) older_mem = 1'b1;
        end
    end

    always_comb begin
        gidx        = 0;
        issue_instr = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                gidx        = i;
                issue_instr = q[i].instr;
            end
        end
        issue_valid = |grant;
    end

    assign do_issue = issue_valid & issue_ready;

    // Dispatch gate. A full queue blocks even if an issue frees a slot this
    // cycle, which keeps disp_ready independent of issue_ready.
    always_comb begin
        dd        = decode(disp_instr);
        dest_mask = dd.has_dest ? (4'b0001 << dd.dest) : 4'b0000;
        war_mask  = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid) war_mask = war_mask | read_mask(q[i].instr);
        end
        disp_ready = live && (state == ST_RUN) && (count_r != FULL) &&
                     ((dest_mask & (busy | war_mask)) == 4'b0000);
    end

    assign do_disp = disp_valid & disp_ready;

    // A source written back in the dispatch cycle is captured as ready.
    always_comb begin
        new_e.valid  = 1'b1;
        new_e.instr  = disp_instr;
        new_e.rdy[0] = !dd.use_src[0] || !busy[dd.src0] || (wb_valid && wb_reg == dd.src0);
        new_e.rdy[1] = !dd.use_src[1] || !busy[dd.src1] || (wb_valid && wb_reg == dd.src1);
    end

    // Wakeup, then collapse over the issued slot, then append the new entry.
    always_comb begin
        q_nxt = q;
        if (wb_valid && state != ST_HALTED) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid && q[i].instr[3:2] == wb_reg) q_nxt[i].rdy[0] = 1'b1;
                if (q[i].valid && q[i].instr[1:0] == wb_reg) q_nxt[i].rdy[1] = 1'b1;
            end
        end
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= gidx) q_nxt[i] = q_nxt[i+1];
            end
            q_nxt[DEPTH-1] = '0;
        end
        wr_idx = do_issue ? int'(count_r) - 1 : int'(count_r);
        if (do_disp) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == wr_idx) q_nxt[i] = new_e;
            end
        end
    end

    // Dispatch set is applied after the writeback clear so it wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_reg] = 1'b0;
        if (do_disp) busy_nxt = busy_nxt | dest_mask;
    end

    always_comb begin
        count_nxt = count_r;
        if (do_disp && !do_issue) count_nxt = count_r + ONE;
        else if (!do_disp && do_issue) count_nxt = count_r - ONE;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (do_disp && dd.cls == CLS_HALT) state_nxt = ST_DRAIN;
            ST_DRAIN: if (do_issue && iclass(issue_instr) == CLS_HALT) state_nxt = ST_HALTED;
            default:  state_nxt = ST_HALTED;
        endcase
        halted = (state == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            busy    <= 4'b0000;
            count_r <= '0;
            live    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
            busy    <= busy_nxt;
            count_r <= count_nxt;
            live    <= 1'b1;
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios plus a randomized phase, each cycle
// compared against a queue-based reference model of the scheduling rules.
module tb_issue_scheduler;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       disp_valid;
    logic [7:0] disp_instr;
    logic       disp_ready;
    logic       wb_valid;
    logic [1:0] wb_reg;
    logic       issue_valid;
    logic [7:0] issue_instr;
    logic       issue_ready;
    logic [2:0] count;
    logic       halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: program-ordered list of waiting instructions, each with
    // the set of source registers still awaiting a writeback.
    logic [7:0] mq_instr[$];
    logic [3:0] mq_pend[$];
    logic [3:0] mbusy;
    int         mstate;   // 0 run, 1 draining, 2 halted
    bit         mlive;

    issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_valid  (disp_valid),
        .disp_instr  (disp_instr),
        .disp_ready  (disp_ready),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_ready (issue_ready),
        .count       (count),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] rd_mask(input logic [7:0] x);
        if (x[7:6] == 2'b00) return (4'b0001 << x[3:2]) | (4'b0001 << x[1:0]);
        if (x[7:6] == 2'b01) return 4'b0001 << x[1:0];
        return 4'b0000;
    endfunction

    function automatic logic [3:0] wr_mask(input logic [7:0] x);
        if (x[7:6] == 2'b00) return 4'b0001 << x[1:0];
        if (x[7:6] == 2'b01 && x[5:4] != 2'b10) return 4'b0001 << x[1:0];
        return 4'b0000;
    endfunction

    function automatic bit is_mem(input logic [7:0] x);
        return x[7:6] == 2'b01 && (x[5:4] == 2'b01 || x[5:4] == 2'b10);
    endfunction

    function automatic bit is_ser(input logic [7:0] x);
        return x[7] == 1'b1;
    endfunction

    function automatic bit is_halt(input logic [7:0] x);
        return x[7:6] == 2'b11;
    endfunction

    function automatic int m_pick();
        bit mem_seen;
        bit ok;
        mem_seen = 0;
        if (mstate == 2) return -1;
        for (int k = 0; k < mq_instr.size(); k++) begin
            ok = (mq_pend[k] == 4'b0000);
            if (is_mem(mq_instr[k]) && mem_seen) ok = 0;
            if (is_ser(mq_instr[k]) && !(k == 0 && mq_instr.size() == 1)) ok = 0;
            if (ok) return k;
            if (is_mem(mq_instr[k])) mem_seen = 1;
        end
        return -1;
    endfunction

    function automatic bit m_dready(input logic [7:0] x);
        logic [3:0] readers;
        readers = 4'b0000;
        foreach (mq_instr[k]) readers = readers | rd_mask(mq_instr[k]);
        return mlive && mstate == 0 && mq_instr.size() < DEPTH &&
               ((wr_mask(x) & (mbusy | readers)) == 4'b0000);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq_instr.delete();
        mq_pend.delete();
        mbusy  = 4'b0000;
        mstate = 0;
        mlive  = 0;
    endtask

    // Called shortly after a rising edge: drive, compare, clock, update model.
    task automatic step(input logic dv, input logic [7:0] di, input logic wv,
                        input logic [1:0] wr, input logic ir);
        int         p;
        bit         dr;
        logic [3:0] wbm;
        disp_valid  = dv;
        disp_instr  = di;
        wb_valid    = wv;
        wb_reg      = wr;
        issue_ready = ir;
        #1;
        p  = m_pick();
        dr = m_dready(di);
        chk("count", 8'(count), 8'(mq_instr.size()));
        chk("issue_valid", {7'b0, issue_valid}, {7'b0, p >= 0});
        chk("issue_instr", issue_instr, (p >= 0) ? mq_instr[p] : 8'h00);
        chk("disp_ready", {7'b0, disp_ready}, {7'b0, dr});
        chk("halted", {7'b0, halted}, {7'b0, mstate == 2});
        @(posedge clk);
        wbm = wv ? (4'b0001 << wr) : 4'b0000;
        if (p >= 0 && ir) begin
            if (is_halt(mq_instr[p])) mstate = 2;
            mq_instr.delete(p);
            mq_pend.delete(p);
        end
        foreach (mq_pend[k]) mq_pend[k] = mq_pend[k] & ~wbm;
        if (dv && dr) begin
            mq_instr.push_back(di);
            mq_pend.push_back(rd_mask(di) & mbusy & ~wbm);
            if (is_halt(di)) mstate = 1;
        end
        mbusy = (mbusy & ~wbm) | ((dv && dr) ? wr_mask(di) : 4'b0000);
        mlive = 1;
        #1;
    endtask

    task automatic idle(input logic ir);
        step(1'b0, 8'h00, 1'b0, 2'd0, ir);
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset();
        rst_n       = 1'b0;
        disp_valid  = 1'b0;
        disp_instr  = 8'h00;
        wb_valid    = 1'b0;
        wb_reg      = 2'd0;
        issue_ready = 1'b0;
        m_reset();
        #1;
        chk("rst_count", 8'(count), 8'h00);
        chk("rst_issue_valid", {7'b0, issue_valid}, 8'h00);
        chk("rst_issue_instr", issue_instr, 8'h00);
        chk("rst_halted", {7'b0, halted}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        do_reset();

        // ADD r0,r1 dispatched with execute ready
        step(1'b1, 8'h04, 1'b0, 2'd0, 1'b1);
        chk("s1_valid", {7'b0, issue_valid}, 8'h01);
        chk("s1_instr", issue_instr, 8'h04);
        chk("s1_count1", 8'(count), 8'h01);
        idle(1'b1);
        chk("s1_count0", 8'(count), 8'h00);
        step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);

        // ADDI r1, then ADD reading r1 waits for the writeback of r1
        step(1'b1, 8'h41, 1'b0, 2'd0, 1'b1);
        step(1'b1, 8'h06, 1'b0, 2'd0, 1'b1);
        chk("s2_wait_valid", {7'b0, issue_valid}, 8'h00);
        chk("s2_wait_count", 8'(count), 8'h01);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 8'h00, 1'b1, 2'd1, 1'b1);
        chk("s2_wake_instr", issue_instr, 8'h06);
        idle(1'b1);
        step(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);

        // Fill the queue with execute stalled, then free one slot
        step(1'b1, 8'h40, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 2'd0, 1'b0);
        chk("s3_full_count", 8'(count), 8'h04);
        disp_valid = 1'b1;
        disp_instr = 8'h80;
        #1;
        chk("s3_full_block", {7'b0, disp_ready}, 8'h00);
        step(1'b1, 8'h80, 1'b0, 2'd0, 1'b1);
        step(1'b1, 8'h80, 1'b0, 2'd0, 1'b0);
        chk("s3_refill_count", 8'(count), 8'h04);
        chk("s3_order", issue_instr, 8'h41);
        repeat (4) idle(1'b1);
        for (int r = 0; r < 4; r++) step(1'b0, 8'h00, 1'b1, 2'(r), 1'b0);

        // LD then ST: memory order holds
        step(1'b1, 8'h50, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h61, 1'b0, 2'd0, 1'b0);
        chk("s4_ld_first", issue_instr, 8'h50);
        idle(1'b1);
        chk("s4_st_second", issue_instr, 8'h61);
        idle(1'b1);
        step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);

        // Randomized traffic (no HALT)
        for (int c = 0; c < 400; c++) begin
            logic [7:0] x;
            x = 8'($urandom);
            if (x[7:6] == 2'b11) x[7:6] = 2'b10;
            step($urandom_range(0, 9) < 6, x, $urandom_range(0, 2) == 0,
                 2'($urandom), $urandom_range(0, 9) < 7);
        end

        // HALT behind two entries
        do_reset();
        step(1'b1, 8'h40, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'hC0, 1'b0, 2'd0, 1'b0);
        chk("s5_count", 8'(count), 8'h03);
        disp_valid = 1'b1;
        disp_instr = 8'h04;
        #1;
        chk("s5_drain_block", {7'b0, disp_ready}, 8'h00);
        idle(1'b1);
        idle(1'b1);
        chk("s5_halt_last", issue_instr, 8'hC0);
        idle(1'b1);
        chk("s5_halted", {7'b0, halted}, 8'h01);
        chk("s5_no_issue", {7'b0, issue_valid}, 8'h00);
        for (int c = 0; c < 6; c++)
            step(1'($urandom), 8'h04, 1'b1, 2'($urandom), 1'b1);
        chk("s5_sticky", {7'b0, halted}, 8'h01);

        // Reset while draining with three entries
        do_reset();
        step(1'b1, 8'h40, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'hC0, 1'b0, 2'd0, 1'b0);
        chk("s6_pre_count", 8'(count), 8'h03);
        do_reset();
        step(1'b1, 8'h04, 1'b0, 2'd0, 1'b1);
        chk("s6_post_instr", issue_instr, 8'h04);
        idle(1'b1);
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
